// File: rtl/radix8_booth_mult_seq_pkg.sv
// Shared types for the sequential radix-8 Booth multiplier: FSM states,
// partial-product select encoding and the Booth digit decoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        PP_ZERO = 3'd0,
        PP_1M   = 3'd1,
        PP_2M   = 3'd2,
        PP_3M   = 3'd3,
        PP_4M   = 3'd4
    } pp_sel_t;

    typedef struct packed {
        logic    neg;
        pp_sel_t sel;
    } booth_dig_t;

    function automatic int num_digits(input int width);
        return (width + 3) / 3;
    endfunction

    // t = {y[3i+2], y[3i+1], y[3i], y[3i-1]}; digit = -4*t3 + 2*t2 + t1 + t0
    function automatic booth_dig_t booth_decode(input logic [3:0] t);
        booth_dig_t d;
        d.neg = t[3] & ~(&t);
        case (t)
            4'b0001, 4'b0010, 4'b1101, 4'b1110: d.sel = PP_1M;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: d.sel = PP_2M;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: d.sel = PP_3M;
            4'b0111, 4'b1000:                   d.sel = PP_4M;
            default:                            d.sel = PP_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/radix8_booth_mult_seq_if.sv
// Operand/result handshake bundle between the issuing stage, the multiplier
// and the result consumer.
interface radix8_booth_mult_seq_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 op_signed;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, op_signed, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, op_signed, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/radix8_booth_mult_seq_cla.sv
// Carry-look-ahead adder with carry-in; 4-bit groups, group carries formed
// from group generate/propagate terms.
module cla_adder #(
    parameter int W = 35
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum
);
    localparam int NG = (W + 3) / 4;

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        logic c_grp;
        logic c_bit;
        logic g_grp;
        logic p_grp;
        o_sum = '0;
        c_grp = i_cin;
        c_bit = 1'b0;
        g_grp = 1'b0;
        p_grp = 1'b0;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (4*k + j < W) begin
                    c_bit = c_grp;
                    for (int m = 0; m < j; m++) begin
                        c_bit = w_g[4*k + m] | (w_p[4*k + m] & c_bit);
                    end
                    o_sum[4*k + j] = w_p[4*k + j] ^ c_bit;
                end
            end
            g_grp = 1'b0;
            p_grp = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (4*k + j < W) begin
                    g_grp = w_g[4*k + j] | (w_p[4*k + j] & g_grp);
                    p_grp = p_grp & w_p[4*k + j];
                end
            end
            c_grp = g_grp | (p_grp & c_grp);
        end
    end
endmodule

// File: rtl/radix8_booth_mult_seq.sv
// Iterative radix-8 Booth multiplier, one digit per cycle on a shared CLA.
// States: IDLE wait for operands | PRE form 3M | ITER accumulate one digit | DONE hold product
module radix8_booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    radix8_booth_mult_seq_if.slave bus
);
    localparam int NDIG = num_digits(WIDTH);
    localparam int AW   = 2*WIDTH + 3;
    localparam int YW   = 3*NDIG + 1;
    localparam int CW   = $clog2(NDIG + 1);

    state_t             r_state, w_next;
    logic [AW-1:0]      r_m, r_m3, r_acc;
    logic [AW-1:0]      w_pp, w_add_a, w_add_b, w_sum;
    logic [YW-1:0]      r_y;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic               w_in_ready, w_accept, w_add_cin, w_last;
    booth_dig_t         w_dig;

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_last   = (r_cnt == '0);
    assign w_dig    = booth_decode(r_y[3:0]);

    always_comb begin
        w_pp = '0;
        case (w_dig.sel)
            PP_1M:   w_pp = r_m;
            PP_2M:   w_pp = r_m << 1;
            PP_3M:   w_pp = r_m3;
            PP_4M:   w_pp = r_m << 2;
            default: w_pp = '0;
        endcase
    end

    // PRE borrows the adder for 3M = 2M + M; ITER uses it to accumulate
    always_comb begin
        w_add_a   = r_acc;
        w_add_b   = w_dig.neg ? ~w_pp : w_pp;
        w_add_cin = w_dig.neg;
        if (r_state == PRE) begin
            w_add_a   = r_m << 1;
            w_add_b   = r_m;
            w_add_cin = 1'b0;
        end
    end

    cla_adder #(.W(AW)) u_cla (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_cin (w_add_cin),
        .o_sum (w_sum)
    );

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = PRE;
            end
            PRE:  w_next = ITER;
            ITER: if (w_last) w_next = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    w_in_ready = 1'b1;
                    w_next     = bus.in_valid ? PRE : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // M and 3M shift up by one digit per iteration instead of shifting the partial product
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_m3      <= '0;
            r_acc     <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_m <= {{(AW-WIDTH){bus.op_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                r_y <= {{(YW-1-WIDTH){bus.op_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier, 1'b0};
            end else if (r_state == PRE) begin
                r_m3  <= w_sum;
                r_acc <= '0;
                r_cnt <= CW'(NDIG - 1);
            end else if (r_state == ITER) begin
                r_acc <= w_sum;
                r_m   <= r_m << 3;
                r_m3  <= r_m3 << 3;
                r_y   <= r_y >> 3;
                r_cnt <= r_cnt - CW'(1);
                if (w_last) r_product <= w_sum[2*WIDTH-1:0];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.product   = r_product;
endmodule

// File: tb/tb_radix8_booth_mult_seq.sv
// Scoreboard bench: directed 16-bit cases, backpressure, mid-run reset and an
// 8-bit random sweep checked against a behavioural multiply.
module tb_radix8_booth_mult_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    radix8_booth_mult_seq_if #(.WIDTH(16)) bus16 ();
    radix8_booth_mult_seq_if #(.WIDTH(8))  bus8 ();

    radix8_booth_mult_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    radix8_booth_mult_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

    logic [31:0] q16_exp[$];
    string       q16_tag[$];
    logic [15:0] q8_exp[$];
    int          q8_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mul_ref(input logic sg, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        logic [63:0] ea, eb, mask, p;
        mask = (64'd1 << w) - 64'd1;
        ea = {32'b0, a} & mask;
        eb = {32'b0, b} & mask;
        if (sg && ea[w-1]) ea = ea | ~mask;
        if (sg && eb[w-1]) eb = eb | ~mask;
        p = ea * eb;
        return p & ((64'd1 << (2*w)) - 64'd1);
    endfunction

    task automatic send16(input string tag, input logic sg, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp, output int waited);
        waited = 0;
        bus16.op_signed    = sg;
        bus16.multiplicand = a;
        bus16.multiplier   = b;
        bus16.in_valid     = 1'b1;
        @(negedge clk);
        while (!bus16.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accepted"}, 64'(bus16.in_ready), 64'd1);
        if (bus16.in_ready) begin
            q16_exp.push_back(exp);
            q16_tag.push_back(tag);
        end
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
    endtask

    // Counts clock edges from the accept edge (counted as 1) until out_valid is seen
    task automatic wait_lat16(input string tag, input int exp_lat);
        int lat = 1;
        @(negedge clk);
        while (!bus16.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check(tag, 64'(lat), 64'(exp_lat));
    endtask

    task automatic send8(input logic sg, input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        logic [63:0] r;
        bus8.op_signed    = sg;
        bus8.multiplicand = a;
        bus8.multiplier   = b;
        bus8.in_valid     = 1'b1;
        @(negedge clk);
        while (!bus8.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("sweep8_accepted", 64'(bus8.in_ready), 64'd1);
        if (bus8.in_ready) begin
            r = mul_ref(sg, {24'b0, a}, {24'b0, b}, 8);
            q8_exp.push_back(r[15:0]);
            q8_cyc.push_back(cyc + 5);
        end
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus16.out_valid && bus16.out_ready) begin
            check("sb16_pending", 64'(q16_exp.size() > 0), 64'd1);
            if (q16_exp.size() > 0)
                check(q16_tag.pop_front(), 64'(bus16.product), 64'(q16_exp.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && bus8.out_valid && bus8.out_ready) begin
            check("sb8_pending", 64'(q8_exp.size() > 0), 64'd1);
            if (q8_exp.size() > 0) begin
                check("sweep8_product", 64'(bus8.product), 64'(q8_exp.pop_front()));
                check("sweep8_latency", 64'(cyc), 64'(q8_cyc.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int n;
        bus16.in_valid = 1'b0; bus16.op_signed = 1'b0; bus16.multiplicand = '0;
        bus16.multiplier = '0; bus16.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op_signed = 1'b0; bus8.multiplicand = '0;
        bus8.multiplier = '0; bus8.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst16_in_ready",  64'(bus16.in_ready),  64'd1);
        check("rst16_out_valid", 64'(bus16.out_valid), 64'd0);
        check("rst16_product",   64'(bus16.product),   64'd0);
        check("rst8_in_ready",   64'(bus8.in_ready),   64'd1);
        check("rst8_out_valid",  64'(bus8.out_valid),  64'd0);
        rst = 1'b0;

        send16("u_3x2", 1'b0, 16'd3, 16'd2, 32'd6, waited);
        wait_lat16("u_3x2_latency", 8);
        @(posedge clk); #1;
        send16("u_4660x0",    1'b0, 16'd4660, 16'd0,    32'd0,         waited);
        send16("u_max_x_max", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001,  waited);
        send16("s_min_x_min", 1'b1, 16'h8000, 16'h8000, 32'h40000000,  waited);
        send16("s_m1_x_5",    1'b1, 16'hFFFF, 16'd5,    32'hFFFFFFFB,  waited);
        send16("s_12345_x_m321", 1'b1, 16'h3039, 16'hFEBF, 32'hFFC38887, waited);

        n = 0;
        while (q16_exp.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        bus16.out_ready = 1'b0;
        send16("bp_first", 1'b0, 16'd100, 16'd200, 32'd20000, waited);
        wait_lat16("bp_first_latency", 8);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_out_valid", 64'(bus16.out_valid), 64'd1);
            check("bp_hold_in_ready",  64'(bus16.in_ready),  64'd0);
            check("bp_hold_product",   64'(bus16.product),   64'd20000);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus16.out_ready = 1'b1;
        send16("bp_next_7x9", 1'b0, 16'd7, 16'd9, 32'd63, waited);
        check("bp_same_edge_accept_wait", 64'(waited), 64'd0);
        wait_lat16("bp_next_latency", 8);

        @(posedge clk); #1;
        send16("rst_abort", 1'b0, 16'd1000, 16'd1000, 32'd1000000, waited);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        q16_exp.delete();
        q16_tag.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready",  64'(bus16.in_ready),  64'd1);
        check("midrst_out_valid", 64'(bus16.out_valid), 64'd0);
        check("midrst_product",   64'(bus16.product),   64'd0);
        repeat (20) @(posedge clk);
        #1;
        send16("post_rst_m123x456", 1'b1, 16'hFF85, 16'd456, 32'hFFFF24E8, waited);
        wait_lat16("post_rst_latency", 8);

        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
            case (i)
                0: send8(1'b1, 8'h80, 8'h80);
                1: send8(1'b0, 8'hFF, 8'hFF);
                2: send8(1'b1, 8'hFF, 8'hFF);
                3: send8(1'b1, 8'h80, 8'h7F);
                default: send8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            endcase
        end

        n = 0;
        while ((q16_exp.size() != 0 || q8_exp.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(q16_exp.size() + q8_exp.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
